// File: rtl/tt_um_nibble_accum.sv
// ============================================================================
// Module   : tt_um_nibble_accum
// Brief    : Multi-term a+b add/subtract accumulator with a wrap or saturate
//            mode, a sticky overflow flag and a valid/ready result handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tt_um_nibble_accum #(
  parameter int W         = 4,
  parameter int ACC_W     = 8,
  parameter int MAX_TERMS = 15,
  localparam int CW       = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CW-1:0]    n_terms,
  input  logic             mode_sat,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic [CW-1:0]    term_cnt
);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [ACC_W-1:0] acc, acc_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [CW-1:0]    n_lat, n_lat_d;
  logic             sat_lat, sat_lat_d;

  logic             beat;
  logic             first;
  logic [CW-1:0]    n_eff;
  logic             sat_eff;
  logic [CW-1:0]    cnt_inc;
  logic [W:0]       sum_ab;
  logic [ACC_W:0]   s_ext;
  logic [ACC_W:0]   acc_ext;
  logic [ACC_W:0]   t_add;
  logic [ACC_W:0]   t_sub;
  logic             add_ovf;
  logic             sub_unf;

  assign in_ready  = (state == ST_ACC) && !clear;
  assign out_valid = (state == ST_DONE);
  assign acc_out   = acc;
  assign ovf       = ovf_q;
  assign term_cnt  = cnt;

  assign beat    = in_valid && in_ready;
  assign first   = (cnt == '0);
  // Transaction length and mode come from the ports only on the first beat.
  assign n_eff   = first ? ((n_terms == '0) ? CW'(1) : n_terms) : n_lat;
  assign sat_eff = first ? mode_sat : sat_lat;
  assign cnt_inc = cnt + CW'(1);

  assign sum_ab  = {1'b0, in_a} + {1'b0, in_b};
  assign s_ext   = {{(ACC_W-W){1'b0}}, sum_ab};
  assign acc_ext = {1'b0, acc};
  assign t_add   = acc_ext + s_ext;
  assign t_sub   = acc_ext - s_ext;
  assign add_ovf = t_add[ACC_W];
  assign sub_unf = (s_ext > acc_ext);

  always_comb begin
    state_d   = state;
    acc_d     = acc;
    ovf_d     = ovf_q;
    cnt_d     = cnt;
    n_lat_d   = n_lat;
    sat_lat_d = sat_lat;
    if (clear || ((state == ST_DONE) && out_ready)) begin
      state_d = ST_ACC;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else if (beat) begin
      n_lat_d   = n_eff;
      sat_lat_d = sat_eff;
      cnt_d     = cnt_inc;
      if (in_sub) begin
        if (sub_unf) begin
          ovf_d = 1'b1;
          acc_d = sat_eff ? '0 : t_sub[ACC_W-1:0];
        end else begin
          acc_d = t_sub[ACC_W-1:0];
        end
      end else begin
        if (add_ovf) begin
          ovf_d = 1'b1;
          acc_d = sat_eff ? '1 : t_add[ACC_W-1:0];
        end else begin
          acc_d = t_add[ACC_W-1:0];
        end
      end
      if (cnt_inc == n_eff) begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_ACC;
      acc     <= '0;
      ovf_q   <= 1'b0;
      cnt     <= '0;
      n_lat   <= CW'(1);
      sat_lat <= 1'b0;
    end else begin
      state   <= state_d;
      acc     <= acc_d;
      ovf_q   <= ovf_d;
      cnt     <= cnt_d;
      n_lat   <= n_lat_d;
      sat_lat <= sat_lat_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tt_um_nibble_accum.sv
// ============================================================================
// Module   : tb_tt_um_nibble_accum
// Brief    : Table vectors, hand-written corner sequences and a randomized
//            run against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tt_um_nibble_accum;

  logic       clk = 1'b0;
  logic       rst, clear, mode_sat, in_valid, in_sub, out_ready;
  logic [3:0] n_terms, in_a, in_b;
  logic       in_ready, out_valid, ovf;
  logic [7:0] acc_out;
  logic [3:0] term_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tt_um_nibble_accum #(.W(4), .ACC_W(8), .MAX_TERMS(15)) dut (
    .clk(clk), .rst(rst), .clear(clear), .n_terms(n_terms), .mode_sat(mode_sat),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .ovf(ovf), .term_cnt(term_cnt)
  );

  typedef struct {
    logic [3:0]       n;
    logic             sat;
    int               nb;
    logic [9:0][3:0]  a;
    logic [9:0][3:0]  b;
    logic [9:0]       sub;
    int               exp_acc;
    int               exp_ovf;
    int               exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 0; in_valid = 0; in_sub = 0; out_ready = 0;
    in_a = 0; in_b = 0; n_terms = 0; mode_sat = 0;
  endtask

  // Beats go back to back; after the first one n_terms/mode_sat are scrambled
  // to show they were latched.
  task automatic drive_txn(input vec_t v);
    for (int i = 0; i < v.nb; i++) begin
      in_valid = 1;
      in_a = v.a[i];
      in_b = v.b[i];
      in_sub = v.sub[i];
      n_terms = (i == 0) ? v.n : 4'($urandom_range(1, 15));
      mode_sat = (i == 0) ? v.sat : ~v.sat;
      step();
    end
    in_valid = 0;
  endtask

  task automatic accept_and_check(input string tag);
    out_ready = 1;
    step();
    out_ready = 0;
    chk({tag, " post-accept out_valid"}, out_valid, 0);
    chk({tag, " post-accept acc_out"}, acc_out, 0);
    chk({tag, " post-accept in_ready"}, in_ready, 1);
  endtask

  task automatic set_uniform(input int k, input logic [3:0] n, input logic sat,
                             input int nb, input logic [3:0] a, input logic [3:0] b,
                             input int ea, input int eo, input int ec);
    vecs[k].n = n; vecs[k].sat = sat; vecs[k].nb = nb;
    vecs[k].a = '0; vecs[k].b = '0; vecs[k].sub = '0;
    for (int i = 0; i < nb; i++) begin
      vecs[k].a[i] = a;
      vecs[k].b[i] = b;
    end
    vecs[k].exp_acc = ea; vecs[k].exp_ovf = eo; vecs[k].exp_cnt = ec;
  endtask

  // Reference model state for the randomized run.
  int m_acc, m_cnt, m_n;
  bit m_ovf, m_sat, m_done;

  initial begin
    idle_inputs();
    rst = 1;

    set_uniform(0, 4'd3, 1'b0, 3, 4'd0, 4'd0, 39, 0, 3);
    vecs[0].a[0] = 3;  vecs[0].b[0] = 5;
    vecs[0].a[1] = 15; vecs[0].b[1] = 15;
    vecs[0].a[2] = 1;  vecs[0].b[2] = 0;
    set_uniform(1, 4'd10, 1'b1, 10, 4'd15, 4'd15, 255, 1, 10);
    set_uniform(2, 4'd10, 1'b0, 10, 4'd15, 4'd15, 44, 1, 10);
    set_uniform(3, 4'd2, 1'b1, 2, 4'd2, 4'd3, 0, 1, 2);
    vecs[3].a[1] = 4; vecs[3].b[1] = 4; vecs[3].sub[1] = 1;
    set_uniform(4, 4'd2, 1'b0, 2, 4'd2, 4'd3, 253, 1, 2);
    vecs[4].a[1] = 4; vecs[4].b[1] = 4; vecs[4].sub[1] = 1;
    set_uniform(5, 4'd0, 1'b0, 1, 4'd7, 4'd9, 16, 0, 1);
    set_uniform(6, 4'd1, 1'b1, 1, 4'd0, 4'd0, 0, 0, 1);
    vecs[6].sub[0] = 1;
    set_uniform(7, 4'd9, 1'b0, 9, 4'd15, 4'd15, 255, 0, 9);
    vecs[7].b[8] = 0;

    step(); step();
    rst = 0;
    chk("reset acc_out", acc_out, 0);
    chk("reset ovf", ovf, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset term_cnt", term_cnt, 0);
    chk("reset in_ready", in_ready, 1);

    for (int k = 0; k < 8; k++) begin
      drive_txn(vecs[k]);
      chk($sformatf("vec%0d out_valid", k), out_valid, 1);
      chk($sformatf("vec%0d acc_out", k), acc_out, vecs[k].exp_acc);
      chk($sformatf("vec%0d ovf", k), ovf, vecs[k].exp_ovf);
      chk($sformatf("vec%0d term_cnt", k), term_cnt, vecs[k].exp_cnt);
      accept_and_check($sformatf("vec%0d", k));
    end

    // DONE is held while the consumer stalls; extra beats are refused.
    drive_txn(vecs[0]);
    in_valid = 1; in_a = 9; in_b = 9;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold in_ready", in_ready, 0);
      step();
      chk("hold out_valid", out_valid, 1);
      chk("hold acc_out", acc_out, 39);
      chk("hold term_cnt", term_cnt, 3);
    end
    in_valid = 0;
    accept_and_check("hold");

    // out_ready with nothing pending does nothing.
    in_valid = 1; in_a = 1; in_b = 1; n_terms = 4; out_ready = 1;
    step();
    out_ready = 0; in_valid = 0;
    chk("idle out_ready acc_out", acc_out, 2);
    chk("idle out_ready term_cnt", term_cnt, 1);
    clear = 1;
    step();
    clear = 0;

    // Abort mid-transaction with a beat offered in the same cycle.
    n_terms = 4;
    in_valid = 1; in_a = 1; in_b = 1;
    step(); step();
    chk("pre-clear acc_out", acc_out, 4);
    clear = 1; in_a = 7; in_b = 7;
    #1;
    chk("clear in_ready", in_ready, 0);
    step();
    clear = 0; in_valid = 0;
    chk("clear acc_out", acc_out, 0);
    chk("clear term_cnt", term_cnt, 0);
    chk("clear out_valid", out_valid, 0);
    chk("clear ovf", ovf, 0);

    // Reset while holding a result.
    drive_txn(vecs[2]);
    chk("pre-rst out_valid", out_valid, 1);
    rst = 1; out_ready = 0;
    step();
    rst = 0;
    chk("rst-done acc_out", acc_out, 0);
    chk("rst-done term_cnt", term_cnt, 0);
    chk("rst-done out_valid", out_valid, 0);
    chk("rst-done ovf", ovf, 0);
    chk("rst-done in_ready", in_ready, 1);

    // Randomized traffic against the arithmetic model.
    m_acc = 0; m_cnt = 0; m_n = 1; m_ovf = 0; m_sat = 0; m_done = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      chk("rnd out_valid", out_valid, int'(m_done));
      chk("rnd acc_out", acc_out, m_acc);
      chk("rnd ovf", ovf, int'(m_ovf));
      chk("rnd term_cnt", term_cnt, m_cnt);
      in_valid  = ($urandom % 4) != 0;
      in_a      = 4'($urandom);
      in_b      = 4'($urandom);
      in_sub    = ($urandom % 3) == 0;
      n_terms   = 4'($urandom);
      mode_sat  = 1'($urandom);
      out_ready = ($urandom % 3) == 0;
      clear     = ($urandom % 25) == 0;
      #1;
      chk("rnd in_ready", in_ready, int'(!m_done && !clear));
      if (clear || (m_done && out_ready)) begin
        m_acc = 0; m_cnt = 0; m_ovf = 0; m_done = 0;
      end else if (in_valid && !m_done) begin
        int s, t;
        if (m_cnt == 0) begin
          m_n = (n_terms == 0) ? 1 : int'(n_terms);
          m_sat = mode_sat;
        end
        s = int'(in_a) + int'(in_b);
        t = in_sub ? m_acc - s : m_acc + s;
        if (t > 255) begin
          m_ovf = 1;
          m_acc = m_sat ? 255 : t - 256;
        end else if (t < 0) begin
          m_ovf = 1;
          m_acc = m_sat ? 0 : t + 256;
        end else begin
          m_acc = t;
        end
        m_cnt++;
        if (m_cnt == m_n) m_done = 1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
